// File: rtl/cam_pkg.sv
// Shared definitions for the 4x4 CAM controller: opcodes, FSM states, row geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cam_pkg;

    localparam int NUM_ROWS = 4;
    localparam int ROW_W    = 2;
    localparam int DATA_W   = 4;

    typedef enum logic [1:0] {
        OP_SEARCH = 2'b00,
        OP_WRITE  = 2'b01,
        OP_INVAL  = 2'b10,
        OP_CLEAR  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        PRECH,
        EVAL,
        WRITE,
        RESP
    } state_t;

    // One-hot wordline for a row index.
    function automatic logic [NUM_ROWS-1:0] row_onehot(input logic [ROW_W-1:0] row);
        return {{(NUM_ROWS-1){1'b0}}, 1'b1} << row;
    endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// Priority encoder over the masked match vector; lowest set index wins.
// Latency: combinational.
// Backpressure: none.
// Ports: vec = masked match vector, hit = any bit set, idx = lowest set index (0 when none).
module cam_prio_enc
    import cam_pkg::*;
(
    input  logic [NUM_ROWS-1:0] vec,
    output logic                hit,
    output logic [ROW_W-1:0]    idx
);

    always_comb begin
        hit = |vec;
        idx = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ROW_W'(i);
            end
        end
    end

endmodule

// File: rtl/cam4x4_ctrl.sv
// Sequencer for a 4-row x 4-bit CAM array: search, write, invalidate, clear-all.
// Latency: search 2+EVAL_CYC cycles, write WR_CYC+1, invalidate/clear-all 1 (accept edge to resp_valid).
// Backpressure: one operation at a time; req_ready only in IDLE, RESP holds until resp_ready.
// Ports: req_* request handshake (op/addr/data), resp_* response handshake (hit/addr/match),
//        cam_wl/cam_bus/cam_pre/cam_eval drive the array, cam_ml returns raw per-row match lines.
module cam4x4_ctrl
    import cam_pkg::*;
#(
    parameter int EVAL_CYC = 1,
    parameter int WR_CYC   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [ROW_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]   req_data,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_hit,
    output logic [ROW_W-1:0]    resp_addr,
    output logic [NUM_ROWS-1:0] resp_match,
    output logic [NUM_ROWS-1:0] cam_wl,
    output logic [DATA_W-1:0]   cam_bus,
    output logic                cam_pre,
    output logic                cam_eval,
    input  logic [NUM_ROWS-1:0] cam_ml
);

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          cyc_cnt;
    logic [ROW_W-1:0]    addr_dat;
    logic [DATA_W-1:0]   key_dat;
    logic [NUM_ROWS-1:0] row_vld;
    logic                rsp_hit_dat;
    logic [ROW_W-1:0]    rsp_addr_dat;
    logic [NUM_ROWS-1:0] rsp_match_dat;

    logic                accept;
    logic                last_cyc;
    op_t                 op_in;
    logic [NUM_ROWS-1:0] srch_match;
    logic                srch_hit;
    logic [ROW_W-1:0]    srch_idx;

    // Gated by rst so the requester never sees ready while the block is held in reset.
    assign req_ready  = (state == IDLE) && !rst;
    assign accept     = req_valid && req_ready;
    assign op_in      = op_t'(req_op);
    assign last_cyc   = (cyc_cnt == 4'd0);

    // Rows that are not valid can never report a match, whatever the array says.
    assign srch_match = cam_ml & row_vld;

    cam_prio_enc u_prio_enc (
        .vec (srch_match),
        .hit (srch_hit),
        .idx (srch_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cam_wl     = '0;
        cam_bus    = '0;
        cam_pre    = 1'b0;
        cam_eval   = 1'b0;
        resp_valid = 1'b0;
        resp_hit   = 1'b0;
        resp_addr  = '0;
        resp_match = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (op_in)
                        OP_SEARCH: state_nxt = PRECH;
                        OP_WRITE:  state_nxt = WRITE;
                        default:   state_nxt = RESP;
                    endcase
                end
            end
            PRECH: begin
                cam_pre   = 1'b1;
                cam_bus   = key_dat;
                state_nxt = EVAL;
            end
            EVAL: begin
                cam_eval = 1'b1;
                cam_bus  = key_dat;
                if (last_cyc) begin
                    state_nxt = RESP;
                end
            end
            WRITE: begin
                cam_wl  = row_onehot(addr_dat);
                cam_bus = key_dat;
                if (last_cyc) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_hit   = rsp_hit_dat;
                resp_addr  = rsp_addr_dat;
                resp_match = rsp_match_dat;
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt       <= '0;
            addr_dat      <= '0;
            key_dat       <= '0;
            row_vld       <= '0;
            rsp_hit_dat   <= 1'b0;
            rsp_addr_dat  <= '0;
            rsp_match_dat <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_dat <= req_addr;
                        key_dat  <= req_data;
                        // Non-search responses carry no match information.
                        rsp_hit_dat   <= 1'b0;
                        rsp_match_dat <= '0;
                        rsp_addr_dat  <= req_addr;
                        case (op_in)
                            OP_SEARCH: cyc_cnt <= 4'(EVAL_CYC - 1);
                            OP_WRITE:  cyc_cnt <= 4'(WR_CYC - 1);
                            OP_INVAL:  row_vld[req_addr] <= 1'b0;
                            OP_CLEAR: begin
                                row_vld      <= '0;
                                rsp_addr_dat <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                EVAL: begin
                    if (last_cyc) begin
                        // Match lines are only trusted at the end of the evaluate window.
                        rsp_hit_dat   <= srch_hit;
                        rsp_addr_dat  <= srch_idx;
                        rsp_match_dat <= srch_match;
                    end else begin
                        cyc_cnt <= cyc_cnt - 4'd1;
                    end
                end
                WRITE: begin
                    if (last_cyc) begin
                        row_vld[addr_dat] <= 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cam4x4_ctrl.sv
// Bench for cam4x4_ctrl: directed scenarios plus randomized traffic against a transaction-level model.
// Latency: model predicts per-cycle strobes and response timing from EVAL_CYC/WR_CYC.
// Backpressure: random resp_ready stalls; junk requests offered while a response is pending.
module tb_cam4x4_ctrl;

    localparam int E = 1;
    localparam int W = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [1:0] req_addr;
    logic [3:0] req_data;
    logic       resp_valid;
    logic       resp_ready;
    logic       resp_hit;
    logic [1:0] resp_addr;
    logic [3:0] resp_match;
    logic [3:0] cam_wl;
    logic [3:0] cam_bus;
    logic       cam_pre;
    logic       cam_eval;
    logic [3:0] cam_ml;

    cam4x4_ctrl #(.EVAL_CYC(E), .WR_CYC(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_hit   (resp_hit),
        .resp_addr  (resp_addr),
        .resp_match (resp_match),
        .cam_wl     (cam_wl),
        .cam_bus    (cam_bus),
        .cam_pre    (cam_pre),
        .cam_eval   (cam_eval),
        .cam_ml     (cam_ml)
    );

    always #5 clk = ~clk;

    // Physical array model: rows latch the bus while their wordline is high.
    logic [3:0] arr [4];
    logic [3:0] junk;
    logic [3:0] live;
    logic       ml_force;
    logic [3:0] ml_val;

    always @(posedge clk) begin
        junk <= 4'($urandom);
        for (int i = 0; i < 4; i++) begin
            if (cam_wl[i]) arr[i] <= cam_bus;
        end
    end

    always_comb begin
        live = '0;
        for (int i = 0; i < 4; i++) live[i] = (arr[i] == cam_bus);
    end

    // Outside evaluate the match lines carry garbage, so early sampling is visible.
    assign cam_ml = cam_eval ? (ml_force ? ml_val : live) : junk;

    // Reference model state and per-cycle expectations (driver-owned).
    logic [3:0] m_valid;
    logic [3:0] ref_words [4];
    logic       chk_en, zero_chk, done;
    logic       exp_ready, exp_rv, exp_hit, exp_pre, exp_eval, exp_bus_chk;
    logic [1:0] exp_raddr;
    logic [3:0] exp_match, exp_wl, exp_bus;
    logic       pin_en, pin_hit;
    logic [1:0] pin_addr;
    logic [3:0] pin_match;

    // Compare-process-owned counters.
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    initial begin : compare
        int cyc;
        cyc = 0;
        while (!done) begin
            @(negedge clk);
            cyc++;
            if (cyc > 60000) begin
                miscompares++;
                $display("FAIL timeout: got %0d cycles, expected under 60000", cyc);
                break;
            end
            if (chk_en && !done) begin
                chk("req_ready", req_ready, exp_ready);
                chk("resp_valid", resp_valid, exp_rv);
                chk("cam_wl", cam_wl, exp_wl);
                chk("cam_pre", cam_pre, exp_pre);
                chk("cam_eval", cam_eval, exp_eval);
                chk("wl_onehot", $countones(cam_wl) <= 1, 1'b1);
                chk("pre_eval_excl", cam_pre & cam_eval, 1'b0);
                if (exp_rv) begin
                    chk("resp_hit", resp_hit, exp_hit);
                    chk("resp_addr", resp_addr, exp_raddr);
                    chk("resp_match", resp_match, exp_match);
                end
                if (exp_bus_chk) chk("cam_bus", cam_bus, exp_bus);
                if (zero_chk) begin
                    chk("rst_hit", resp_hit, 1'b0);
                    chk("rst_addr", resp_addr, 2'b00);
                    chk("rst_match", resp_match, 4'b0000);
                    chk("rst_bus", cam_bus, 4'b0000);
                end
                if (pin_en) begin
                    chk("pin_hit", resp_hit, pin_hit);
                    chk("pin_addr", resp_addr, pin_addr);
                    chk("pin_match", resp_match, pin_match);
                end
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        chk_en = 1'b1; zero_chk = 1'b0; pin_en = 1'b0;
        exp_ready = 1'b1; exp_rv = 1'b0; exp_wl = '0;
        exp_pre = 1'b0; exp_eval = 1'b0; exp_bus_chk = 1'b0;
    endtask

    task automatic set_reset_exp();
        set_idle();
        exp_ready = 1'b0;
        zero_chk  = 1'b1;
    endtask

    // Full transaction: offer, accept, predict each busy cycle, then the response with a stall.
    task automatic run_req(input logic [1:0] op, input logic [1:0] addr, input logic [3:0] data,
                           input int hold, input logic pin, input logic ph,
                           input logic [1:0] pa, input logic [3:0] pm);
        logic [3:0] raw, mt;
        logic [1:0] ra;
        int lat;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_data = data;
        tick();
        req_valid = 1'b0;
        req_op = 2'($urandom); req_addr = 2'($urandom); req_data = 4'($urandom);
        exp_ready = 1'b0;
        mt = '0; ra = addr;
        case (op)
            2'b00: begin
                for (int i = 0; i < 4; i++) raw[i] = (ref_words[i] == data);
                if (ml_force) raw = ml_val;
                mt = raw & m_valid;
                ra = 2'b00;
                for (int i = 3; i >= 0; i--) if (mt[i]) ra = 2'(i);
                lat = 2 + E;
            end
            2'b01: lat = W + 1;
            2'b10: begin m_valid[addr] = 1'b0; lat = 1; end
            default: begin m_valid = '0; ra = 2'b00; lat = 1; end
        endcase
        for (int k = 1; k < lat; k++) begin
            exp_pre     = (op == 2'b00) && (k == 1);
            exp_eval    = (op == 2'b00) && (k > 1);
            exp_wl      = (op == 2'b01) ? (4'b0001 << addr) : 4'b0000;
            exp_bus_chk = 1'b1;
            exp_bus     = data;
            tick();
        end
        if (op == 2'b01) begin
            m_valid[addr]   = 1'b1;
            ref_words[addr] = data;
        end
        exp_pre = 1'b0; exp_eval = 1'b0; exp_wl = '0; exp_bus_chk = 1'b0;
        exp_rv = 1'b1; exp_hit = |mt; exp_match = mt; exp_raddr = ra;
        pin_en = pin; pin_hit = ph; pin_addr = pa; pin_match = pm;
        // A competing request during the response must not be taken.
        req_valid = 1'($urandom);
        resp_ready = 1'b0;
        repeat (hold) tick();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        set_idle();
    endtask

    initial begin : driver
        logic [1:0] op;
        int r;
        done = 1'b0; ml_force = 1'b0; ml_val = '0;
        m_valid = '0;
        for (int i = 0; i < 4; i++) ref_words[i] = '0;
        exp_hit = 1'b0; exp_raddr = '0; exp_match = '0; exp_bus = '0;
        pin_hit = 1'b0; pin_addr = '0; pin_match = '0;
        resp_ready = 1'b0;
        req_valid = 1'b1; req_op = 2'b01; req_addr = 2'd1; req_data = 4'hF;
        rst = 1'b1;
        set_reset_exp();
        repeat (3) tick();
        req_valid = 1'b0;
        rst = 1'b0;
        chk_en = 1'b0;
        tick();
        set_idle();

        // Array-backed search after a write.
        run_req(2'b11, 2'd0, 4'h0, 0, 1'b1, 1'b0, 2'd0, 4'b0000);
        run_req(2'b01, 2'd2, 4'hA, 0, 1'b1, 1'b0, 2'd2, 4'b0000);
        run_req(2'b00, 2'd0, 4'hA, 1, 1'b1, 1'b1, 2'd2, 4'b0100);

        // Forced match lines masked by valid bits.
        run_req(2'b11, 2'd0, 4'h0, 0, 1'b0, 1'b0, 2'd0, 4'b0000);
        run_req(2'b01, 2'd1, 4'h5, 0, 1'b0, 1'b0, 2'd0, 4'b0000);
        run_req(2'b01, 2'd3, 4'h5, 0, 1'b0, 1'b0, 2'd0, 4'b0000);
        ml_force = 1'b1; ml_val = 4'b1010;
        run_req(2'b00, 2'd0, 4'h5, 0, 1'b1, 1'b1, 2'd1, 4'b1010);
        run_req(2'b10, 2'd1, 4'h0, 0, 1'b1, 1'b0, 2'd1, 4'b0000);
        run_req(2'b00, 2'd0, 4'h5, 0, 1'b1, 1'b1, 2'd3, 4'b1000);
        run_req(2'b10, 2'd1, 4'h0, 0, 1'b1, 1'b0, 2'd1, 4'b0000);

        // All lines asserted, no valid rows.
        run_req(2'b11, 2'd2, 4'h0, 0, 1'b1, 1'b0, 2'd0, 4'b0000);
        ml_val = 4'b1111;
        run_req(2'b00, 2'd0, 4'h3, 0, 1'b1, 1'b0, 2'd0, 4'b0000);
        ml_force = 1'b0;

        // Long response stall, wordline duration on row 0, overwrite of a valid row.
        run_req(2'b01, 2'd0, 4'hC, 2, 1'b0, 1'b0, 2'd0, 4'b0000);
        run_req(2'b01, 2'd0, 4'h6, 0, 1'b0, 1'b0, 2'd0, 4'b0000);
        run_req(2'b00, 2'd0, 4'h6, 5, 1'b1, 1'b1, 2'd0, 4'b0001);

        // Reset during evaluate after a completed write.
        run_req(2'b01, 2'd2, 4'h9, 0, 1'b0, 1'b0, 2'd0, 4'b0000);
        req_valid = 1'b1; req_op = 2'b00; req_addr = 2'd0; req_data = 4'h9;
        tick();
        req_valid = 1'b0;
        exp_ready = 1'b0; exp_pre = 1'b1; exp_bus_chk = 1'b1; exp_bus = 4'h9;
        tick();
        #1;
        rst = 1'b1;
        m_valid = '0;
        set_reset_exp();
        repeat (2) tick();
        rst = 1'b0;
        chk_en = 1'b0;
        tick();
        set_idle();
        run_req(2'b00, 2'd0, 4'h9, 0, 1'b1, 1'b0, 2'd0, 4'b0000);

        // Randomized traffic.
        for (int t = 0; t < 150; t++) begin
            r = $urandom_range(0, 9);
            op = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            ml_force = (op == 2'b00) && ($urandom_range(0, 3) == 0);
            ml_val = 4'($urandom);
            run_req(op, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3) * 5),
                    $urandom_range(0, 3), 1'b0, 1'b0, 2'd0, 4'b0000);
            ml_force = 1'b0;
        end

        tick();
        done = 1'b1;
    end

endmodule

// File: doc/cam4x4_ctrl.md
CAM4X4_CTRL -- requirements
Module: cam4x4_ctrl

Interface
REQ-001 The block SHALL accept parameter EVAL_CYC, default 1, giving match-line evaluate cycles (range 1-15).
REQ-002 The block SHALL accept parameter WR_CYC, default 1, giving wordline-high cycles per write (range 1-15).
REQ-003 Ports SHALL be:
  clk  in  1  sole clock, rising edge
  rst  in  1  asynchronous active-high reset
  req_valid  in  1  request offered
  req_ready  out  1  controller can accept
  req_op  in  2  00 search, 01 write, 10 invalidate, 11 clear-all
  req_addr  in  2  target row for write/invalidate
  req_data  in  4  search key or write word
  resp_valid  out  1  response available
  resp_ready  in  1  requester consumes response
  resp_hit  out  1  at least one valid row matched (search only)
  resp_addr  out  2  lowest-index matching valid row
  resp_match  out  4  per-row match vector ANDed with valid bits
  cam_wl  out  4  one-hot row write wordline to array
  cam_bus  out  4  data/key driven onto array bitlines
  cam_pre  out  1  match-line precharge strobe
  cam_eval  out  1  match-line evaluate strobe
  cam_ml  in  4  raw match lines from array (4-input AND per row)

Function
REQ-004 A request SHALL transfer on a rising clk edge where req_valid and req_ready are both 1.
REQ-005 req_ready SHALL be 1 only in state IDLE.
REQ-006 FSM states SHALL be IDLE, PRECH, EVAL, WRITE, RESP.
REQ-007 IDLE: search goes to PRECH; write goes to WRITE; invalidate and clear-all update valid bits in the accept cycle and go to RESP.
REQ-008 PRECH SHALL last exactly 1 cycle with cam_pre=1, cam_bus=captured key, then go to EVAL.
REQ-009 EVAL SHALL last EVAL_CYC cycles with cam_eval=1 and cam_bus held; cam_ml SHALL be sampled on the final EVAL cycle only, then go to RESP.
REQ-010 WRITE SHALL last WR_CYC cycles with cam_wl=one-hot of captured addr and cam_bus=captured data; the row valid bit SHALL set on the final WRITE cycle; then go to RESP.
REQ-011 resp_match SHALL equal sampled cam_ml AND valid[3:0]; resp_hit SHALL be OR of resp_match; resp_addr SHALL be the lowest set index, 0 when none.
REQ-012 For write, invalidate and clear-all, resp_hit SHALL be 0, resp_match 0, resp_addr = captured addr (0 for clear-all).
REQ-013 RESP SHALL hold resp_valid=1 and all resp_* stable until resp_ready=1, then return to IDLE on that edge; a new request SHALL NOT be accepted on the same edge.
REQ-014 Search latency from accept edge to resp_valid high SHALL be 1+EVAL_CYC+1 cycles; write latency WR_CYC+1; invalidate/clear-all 1.
REQ-015 Writing an already-valid row SHALL overwrite it and keep it valid; invalidating an invalid row SHALL be a no-op with normal response.
REQ-016 cam_wl, cam_pre, cam_eval SHALL be 0 outside their states; cam_wl SHALL never have more than one bit set; cam_pre and cam_eval SHALL never be 1 together.
REQ-017 req_* inputs SHALL be captured at accept; changes afterwards SHALL not affect the operation.

Reset
REQ-018 rst=1 SHALL asynchronously force IDLE, valid bits 0000, req_ready 0 while asserted, resp_valid 0, resp_hit 0, resp_addr 00, resp_match 0000, cam_wl 0000, cam_bus 0000, cam_pre 0, cam_eval 0.
REQ-019 Reset mid-operation SHALL abort it with no valid-bit update and no response; req_ready SHALL be 1 on the first clk edge after rst deasserts.

Structure
REQ-020 Opcode encodings, FSM state type and row count (4) SHALL live in shared package cam_pkg.
REQ-021 A sub-module cam_prio_enc (4-bit vector -> hit, 2-bit index, lowest wins) SHALL implement REQ-011.

Verification
REQ-022 Write 1010 to row 2, search 1010 with array model matching row 2 -> resp_hit=1, resp_addr=2, resp_match=0100, resp_valid 3 cycles after accept (EVAL_CYC=1).
REQ-023 Rows 1 and 3 valid, cam_ml=1010 -> resp_match=1010, resp_addr=1; then invalidate row 1, repeat -> resp_match=1000, resp_addr=3.
REQ-024 cam_ml=1111 with no valid rows -> resp_hit=0, resp_match=0000, resp_addr=0.
REQ-025 resp_ready held 0 for 5 cycles -> resp_* stable, req_ready=0 throughout; release -> IDLE next edge.
REQ-026 rst asserted in EVAL after a pending write completed -> all outputs reset immediately, valid=0000, no response; search afterwards -> resp_hit=0.
REQ-027 WR_CYC=3 write to row 0 -> cam_wl=0001 exactly 3 cycles, cam_pre/cam_eval never overlap, resp_valid at cycle 4.
